// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator: registered fetch address with
// trap > mret > branch redirect priority and one stored redirect across AHB stalls.
module pc_gen_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int unsigned     IALIGN    = 32
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            ahb_ready_in,
   input  logic            stall_in,
   input  logic            trap_valid_in,
   input  logic [XLEN-1:0] trap_addr_in,
   input  logic            mret_valid_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-1:0] branch_addr_in,
   output logic [XLEN-1:0] iaddr_out,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus4_out,
   output logic            mis_instr_out,
   output logic            pending_out,
   output logic [1:0]      state_out
);

   localparam logic [1:0] ST_BOOT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HOLD = 2'b10;

   localparam logic [1:0] PRIO_BRANCH = 2'd1;
   localparam logic [1:0] PRIO_MRET   = 2'd2;
   localparam logic [1:0] PRIO_TRAP   = 2'd3;

   localparam logic            IALIGN_32  = (IALIGN == 32);
   localparam logic [XLEN-1:0] HALF_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, ~IALIGN_32, 1'b0};
   localparam logic [XLEN-1:0] FOUR       = {{(XLEN-3){1'b0}}, 3'b100};

   logic [XLEN-1:0] iaddr_q, iaddr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_addr_q, pend_addr_d;
   logic [1:0]      pend_prio_q, pend_prio_d;
   logic            pend_q, pend_d;
   logic            mis_q, mis_d;
   logic [1:0]      state_q, state_d;

   logic            accept;
   logic            br_mis;
   logic            rd_valid;
   logic [1:0]      rd_prio;
   logic [XLEN-1:0] rd_addr;
   logic            rd_wins;
   logic [XLEN-1:0] next_addr;
   logic [XLEN-1:0] plus4;

   assign accept = ahb_ready_in & ~stall_in;
   assign plus4  = iaddr_q + FOUR;
   assign br_mis = IALIGN_32 & branch_addr_in[1];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      rd_valid = 1'b0;
      rd_prio  = 2'd0;
      rd_addr  = '0;
      if (trap_valid_in) begin
         rd_valid = 1'b1;
         rd_prio  = PRIO_TRAP;
         rd_addr  = trap_addr_in & ALIGN_MASK;
      end else if (mret_valid_in) begin
         rd_valid = 1'b1;
         rd_prio  = PRIO_MRET;
         rd_addr  = epc_in & ALIGN_MASK;
      end else if (branch_taken_in && !br_mis) begin
         rd_valid = 1'b1;
         rd_prio  = PRIO_BRANCH;
         rd_addr  = branch_addr_in & HALF_MASK;
      end
   end

   // A stored redirect yields only to a fresh one of equal or higher priority.
   assign rd_wins   = rd_valid & (~pend_q | (rd_prio >= pend_prio_q));
   assign next_addr = rd_wins ? rd_addr : (pend_q ? pend_addr_q : plus4);

   always_comb begin
      iaddr_d     = iaddr_q;
      pc_d        = pc_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_prio_d = pend_prio_q;
      state_d     = state_q;
      mis_d       = branch_taken_in & br_mis;
      if (accept) begin
         pc_d    = iaddr_q;
         iaddr_d = next_addr;
         pend_d  = 1'b0;
         state_d = ST_RUN;
      end else if (rd_wins) begin
         pend_d      = 1'b1;
         pend_addr_d = rd_addr;
         pend_prio_d = rd_prio;
         state_d     = ST_HOLD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         iaddr_q     <= BOOT_ADDR;
         pc_q        <= BOOT_ADDR;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_prio_q <= 2'd0;
         mis_q       <= 1'b0;
         state_q     <= ST_BOOT;
      end else begin
         iaddr_q     <= iaddr_d;
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_prio_q <= pend_prio_d;
         mis_q       <= mis_d;
         state_q     <= state_d;
      end
   end

   assign iaddr_out     = iaddr_q;
   assign pc_out        = pc_q;
   assign pc_plus4_out  = plus4;
   assign mis_instr_out = mis_q;
   assign pending_out   = pend_q;
   assign state_out     = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: an IALIGN=32 instance plus an IALIGN=16 instance
// sharing stimulus, checked against hand-computed fetch addresses.
module tb_pc_gen_unit;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        ahb_ready_in, stall_in;
   logic        trap_valid_in, mret_valid_in, branch_taken_in;
   logic [31:0] trap_addr_in, epc_in, branch_addr_in;

   logic [31:0] iaddr_out, pc_out, pc_plus4_out;
   logic        mis_instr_out, pending_out;
   logic [1:0]  state_out;

   logic [31:0] iaddr16, pc16, plus4_16;
   logic        mis16, pend16;
   logic [1:0]  state16;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .IALIGN(32)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .ahb_ready_in(ahb_ready_in), .stall_in(stall_in),
      .trap_valid_in(trap_valid_in), .trap_addr_in(trap_addr_in),
      .mret_valid_in(mret_valid_in), .epc_in(epc_in),
      .branch_taken_in(branch_taken_in), .branch_addr_in(branch_addr_in),
      .iaddr_out(iaddr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
      .mis_instr_out(mis_instr_out), .pending_out(pending_out), .state_out(state_out)
   );

   pc_gen_unit #(.XLEN(32), .BOOT_ADDR(32'h0), .IALIGN(16)) dut16 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .ahb_ready_in(ahb_ready_in), .stall_in(stall_in),
      .trap_valid_in(trap_valid_in), .trap_addr_in(trap_addr_in),
      .mret_valid_in(mret_valid_in), .epc_in(epc_in),
      .branch_taken_in(branch_taken_in), .branch_addr_in(branch_addr_in),
      .iaddr_out(iaddr16), .pc_out(pc16), .pc_plus4_out(plus4_16),
      .mis_instr_out(mis16), .pending_out(pend16), .state_out(state16)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_events();
      trap_valid_in   = 1'b0;
      mret_valid_in   = 1'b0;
      branch_taken_in = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; ahb_ready_in = 1'b1; stall_in = 1'b0;
      trap_addr_in = '0; epc_in = '0; branch_addr_in = '0;
      clear_events();
      tick(); tick();
      checks++; if (iaddr_out !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h exp %h", iaddr_out, 32'h0); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL reset_state: got %b exp 00", state_out); end
      checks++; if ({pending_out, mis_instr_out} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {pending_out, mis_instr_out}); end
      rst_n_in = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_seq [3];
      exp_seq = '{32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (iaddr_out !== exp_seq[i]) begin errors++; $display("FAIL seq_iaddr[%0d]: got %h exp %h", i, iaddr_out, exp_seq[i]); end
         checks++; if (state_out !== 2'b01) begin errors++; $display("FAIL seq_state[%0d]: got %b exp 01", i, state_out); end
      end
      checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL seq_pc: got %h exp %h", pc_out, 32'h8); end
   endtask

   task automatic test_hold_redirect();
      branch_taken_in = 1'b1; branch_addr_in = 32'h100;
      tick();
      checks++; if (iaddr_out !== 32'h100) begin errors++; $display("FAIL br_direct: got %h exp %h", iaddr_out, 32'h100); end
      ahb_ready_in = 1'b0; branch_addr_in = 32'h200;
      tick();
      clear_events();
      checks++; if ({state_out, pending_out} !== 3'b101) begin errors++; $display("FAIL hold_enter: got %b exp 101", {state_out, pending_out}); end
      tick(); tick();
      checks++; if (iaddr_out !== 32'h100) begin errors++; $display("FAIL hold_stable: got %h exp %h", iaddr_out, 32'h100); end
      checks++; if (pending_out !== 1'b1) begin errors++; $display("FAIL hold_pending: got %b exp 1", pending_out); end
      ahb_ready_in = 1'b1;
      tick();
      checks++; if (iaddr_out !== 32'h200) begin errors++; $display("FAIL hold_apply: got %h exp %h", iaddr_out, 32'h200); end
      checks++; if ({state_out, pending_out} !== 3'b010) begin errors++; $display("FAIL hold_exit: got %b exp 010", {state_out, pending_out}); end
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL hold_pc: got %h exp %h", pc_out, 32'h100); end
   endtask

   task automatic test_simultaneous();
      trap_valid_in = 1'b1; trap_addr_in = 32'h80;
      mret_valid_in = 1'b1; epc_in = 32'h300;
      branch_taken_in = 1'b1; branch_addr_in = 32'h400;
      tick();
      clear_events();
      checks++; if (iaddr_out !== 32'h80) begin errors++; $display("FAIL simul_trap: got %h exp %h", iaddr_out, 32'h80); end
      checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL simul_pending: got %b exp 0", pending_out); end
   endtask

   task automatic test_priority();
      // stored branch replaced by a later trap
      ahb_ready_in = 1'b0; branch_taken_in = 1'b1; branch_addr_in = 32'h400;
      tick();
      branch_taken_in = 1'b0; trap_valid_in = 1'b1; trap_addr_in = 32'h80;
      tick();
      trap_valid_in = 1'b0; ahb_ready_in = 1'b1;
      tick();
      checks++; if (iaddr_out !== 32'h80) begin errors++; $display("FAIL prio_trap_over_branch: got %h exp %h", iaddr_out, 32'h80); end
      tick();
      checks++; if (iaddr_out !== 32'h84) begin errors++; $display("FAIL prio_branch_lost: got %h exp %h", iaddr_out, 32'h84); end
      // stored trap beats a fresh branch at accept
      ahb_ready_in = 1'b0; trap_valid_in = 1'b1; trap_addr_in = 32'h40;
      tick();
      trap_valid_in = 1'b0; ahb_ready_in = 1'b1; branch_taken_in = 1'b1; branch_addr_in = 32'h500;
      tick();
      branch_taken_in = 1'b0;
      checks++; if (iaddr_out !== 32'h40) begin errors++; $display("FAIL prio_stored_trap: got %h exp %h", iaddr_out, 32'h40); end
      checks++; if (pc_out !== 32'h84) begin errors++; $display("FAIL prio_pc: got %h exp %h", pc_out, 32'h84); end
      // equal priority: newest branch wins
      ahb_ready_in = 1'b0; branch_taken_in = 1'b1; branch_addr_in = 32'h600;
      tick();
      branch_addr_in = 32'h700;
      tick();
      branch_taken_in = 1'b0; ahb_ready_in = 1'b1;
      tick();
      checks++; if (iaddr_out !== 32'h700) begin errors++; $display("FAIL prio_newest: got %h exp %h", iaddr_out, 32'h700); end
      // stall blocks accept even with ready; mret EPC bit0 cleared
      stall_in = 1'b1; mret_valid_in = 1'b1; epc_in = 32'h301;
      tick();
      mret_valid_in = 1'b0;
      checks++; if ({iaddr_out, state_out, pending_out} !== {32'h700, 3'b101}) begin errors++; $display("FAIL stall_hold: got %h/%b%b exp 00000700/101", iaddr_out, state_out, pending_out); end
      stall_in = 1'b0;
      tick();
      checks++; if (iaddr_out !== 32'h300) begin errors++; $display("FAIL stall_mret_apply: got %h exp %h", iaddr_out, 32'h300); end
   endtask

   task automatic test_alignment();
      branch_taken_in = 1'b1; branch_addr_in = 32'h102;
      tick();
      branch_taken_in = 1'b0;
      checks++; if (iaddr_out !== 32'h304) begin errors++; $display("FAIL mis_seq: got %h exp %h", iaddr_out, 32'h304); end
      checks++; if (mis_instr_out !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b exp 1", mis_instr_out); end
      checks++; if (pending_out !== 1'b0) begin errors++; $display("FAIL mis_not_stored: got %b exp 0", pending_out); end
      checks++; if (iaddr16 !== 32'h102) begin errors++; $display("FAIL ialign16_taken: got %h exp %h", iaddr16, 32'h102); end
      checks++; if ({mis16, pend16, state16} !== 4'b0001) begin errors++; $display("FAIL ialign16_flags: got %b exp 0001", {mis16, pend16, state16}); end
      checks++; if ({pc16, plus4_16} !== {32'h300, 32'h106}) begin errors++; $display("FAIL ialign16_pc: got %h/%h exp 00000300/00000106", pc16, plus4_16); end
      tick();
      checks++; if ({iaddr_out, mis_instr_out} !== {32'h308, 1'b0}) begin errors++; $display("FAIL mis_one_cycle: got %h/%b exp 00000308/0", iaddr_out, mis_instr_out); end
      trap_valid_in = 1'b1; trap_addr_in = 32'h203;
      tick();
      trap_valid_in = 1'b0;
      checks++; if (iaddr_out !== 32'h200) begin errors++; $display("FAIL trap_align32: got %h exp %h", iaddr_out, 32'h200); end
      checks++; if (iaddr16 !== 32'h202) begin errors++; $display("FAIL trap_align16: got %h exp %h", iaddr16, 32'h202); end
   endtask

   task automatic test_wrap_reset();
      trap_valid_in = 1'b1; trap_addr_in = 32'hFFFF_FFFF;
      tick();
      trap_valid_in = 1'b0;
      checks++; if (iaddr_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h exp %h", iaddr_out, 32'hFFFF_FFFC); end
      checks++; if (pc_plus4_out !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h exp %h", pc_plus4_out, 32'h0); end
      tick();
      checks++; if (iaddr_out !== 32'h0) begin errors++; $display("FAIL wrap_iaddr: got %h exp %h", iaddr_out, 32'h0); end
      tick();
      ahb_ready_in = 1'b0; branch_taken_in = 1'b1; branch_addr_in = 32'h200;
      tick();
      branch_taken_in = 1'b0;
      checks++; if ({iaddr_out, state_out, pending_out} !== {32'h4, 3'b101}) begin errors++; $display("FAIL rst_hold_setup: got %h/%b%b exp 00000004/101", iaddr_out, state_out, pending_out); end
      #2 rst_n_in = 1'b0;
      #1;
      checks++; if (iaddr_out !== 32'h0) begin errors++; $display("FAIL rst_async_iaddr: got %h exp %h", iaddr_out, 32'h0); end
      checks++; if ({state_out, pending_out, pc_out} !== {3'b000, 32'h0}) begin errors++; $display("FAIL rst_async_state: got %b%b/%h exp 000/00000000", state_out, pending_out, pc_out); end
      rst_n_in = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_hold_redirect();
      test_simultaneous();
      test_priority();
      test_alignment();
      test_wrap_reset();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
